// File: rtl/simd_eu_if.sv
`default_nettype none
// ============================================================================
//  Module      : simd_eu_if
//  Description : Issue / result bus between a reservation station (master)
//                and the SIMD execution unit (slave). Carries flush, the
//                issue handshake with packed operands and tag, and the
//                result handshake with exception status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface simd_eu_if #(
   parameter int XLEN       = 64,
   parameter int IDX_W      = 4,
   parameter int EU_CTL_LEN = 5,
   parameter int EXCEPT_LEN = 2
);
   logic                  flush_i;
   logic                  issue_valid_i;
   logic                  issue_ready_o;
   logic [EU_CTL_LEN-1:0] eu_ctl_i;
   logic [XLEN-1:0]       rs1_i;
   logic [XLEN-1:0]       rs2_i;
   logic [IDX_W-1:0]      entry_idx_i;
   logic                  result_valid_o;
   logic                  result_ready_i;
   logic [XLEN-1:0]       result_o;
   logic [IDX_W-1:0]      entry_idx_o;
   logic                  except_raised_o;
   logic [EXCEPT_LEN-1:0] except_code_o;

   // Reservation-station side
   modport master (
      output flush_i, issue_valid_i, eu_ctl_i, rs1_i, rs2_i, entry_idx_i,
      output result_ready_i,
      input  issue_ready_o, result_valid_o, result_o, entry_idx_o,
      input  except_raised_o, except_code_o
   );

   // Execution-unit side
   modport slave (
      input  flush_i, issue_valid_i, eu_ctl_i, rs1_i, rs2_i, entry_idx_i,
      input  result_ready_i,
      output issue_ready_o, result_valid_o, result_o, entry_idx_o,
      output except_raised_o, except_code_o
   );
endinterface
`default_nettype wire

// File: rtl/simd_eu.sv
`default_nettype none
// ============================================================================
//  Module      : simd_eu
//  Description : Packed-SIMD integer execution unit. Lane widths 8/16/32/64,
//                ops ADD/SUB/MIN/MAX/AND/OR/XOR, PIPE_DEPTH-stage elastic
//                pipeline with valid/ready on both sides, in-order results,
//                synchronous flush and asynchronous active-high reset.
//                Optional macro SIMD_SATURATION_EN: when defined, ADD/SUB
//                saturate signed per lane; otherwise they wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module simd_eu #(
   parameter int XLEN       = 64,
   parameter int RS_DEPTH   = 16,
   parameter int PIPE_DEPTH = 2,
   parameter int EU_CTL_LEN = 5,
   parameter int EXCEPT_LEN = 2
) (
   input  logic     clk_i,
   input  logic     rst_i,
   simd_eu_if.slave bus
);
   localparam int IDX_W = $clog2(RS_DEPTH);

   localparam logic [2:0] c_OP_ADD = 3'b000;
   localparam logic [2:0] c_OP_SUB = 3'b001;
   localparam logic [2:0] c_OP_MIN = 3'b010;
   localparam logic [2:0] c_OP_MAX = 3'b011;
   localparam logic [2:0] c_OP_AND = 3'b100;
   localparam logic [2:0] c_OP_OR  = 3'b101;
   localparam logic [2:0] c_OP_XOR = 3'b110;
   localparam logic [2:0] c_OP_ILL = 3'b111;

   // One lane, operands already sign-extended to 64 bits. ADD/SUB keep a
   // 65-bit result so the caller can detect signed overflow.
   function automatic logic [64:0] f_lane(input logic [2:0]  op,
                                          input logic [63:0] a,
                                          input logic [63:0] b);
      logic [64:0] r;
      case (op)
         c_OP_ADD: r = {a[63], a} + {b[63], b};
         c_OP_SUB: r = {a[63], a} - {b[63], b};
         c_OP_MIN: r = ($signed(a) < $signed(b)) ? {1'b0, a} : {1'b0, b};
         c_OP_MAX: r = ($signed(a) > $signed(b)) ? {1'b0, a} : {1'b0, b};
         c_OP_AND: r = {1'b0, a & b};
         c_OP_OR:  r = {1'b0, a | b};
         c_OP_XOR: r = {1'b0, a ^ b};
         default:  r = '0;
      endcase
      return r;
   endfunction

   logic [2:0]            w_op;
   logic [1:0]            w_wsel;
   logic                  w_illegal;
   logic [XLEN-1:0]       w_res;
   logic [PIPE_DEPTH-1:0] w_acc;

   logic [PIPE_DEPTH-1:0] r_vld;
   logic [PIPE_DEPTH-1:0] r_exc;
   logic [XLEN-1:0]       r_res  [PIPE_DEPTH];
   logic [IDX_W-1:0]      r_tag  [PIPE_DEPTH];
   logic [EXCEPT_LEN-1:0] r_code [PIPE_DEPTH];

   assign w_op      = bus.eu_ctl_i[2:0];
   assign w_wsel    = bus.eu_ctl_i[4:3];
   // 64-bit lanes do not exist on a 32-bit datapath
   assign w_illegal = (w_op == c_OP_ILL) || ((w_wsel == 2'b11) && (XLEN == 32));

   // Per-lane datapath: extract, sign-extend, operate, optionally clamp, repack
   always_comb begin
      int          w_lw;
      logic [63:0] w_a64;
      logic [63:0] w_b64;
      logic [63:0] w_sa;
      logic [63:0] w_sb;
      logic [63:0] w_mask;
      logic [63:0] w_lane;
      logic [63:0] w_pack;
      logic [64:0] w_t;
`ifdef SIMD_SATURATION_EN
      logic [63:0] w_lim;
`endif
      case (w_wsel)
         2'b00:   w_lw = 8;
         2'b01:   w_lw = 16;
         2'b10:   w_lw = 32;
         default: w_lw = 64;
      endcase
      w_a64             = '0;
      w_b64             = '0;
      w_a64[XLEN-1:0]   = bus.rs1_i;
      w_b64[XLEN-1:0]   = bus.rs2_i;
      w_mask            = (w_lw == 64) ? '1 : ((64'd1 << w_lw) - 64'd1);
`ifdef SIMD_SATURATION_EN
      // Largest positive lane value; its complement is the most negative one
      w_lim             = (64'd1 << (w_lw - 1)) - 64'd1;
`endif
      w_pack            = '0;
      w_sa              = '0;
      w_sb              = '0;
      w_t               = '0;
      w_lane            = '0;
      for (int i = 0; i < XLEN / 8; i++) begin
         if (i < XLEN / w_lw) begin
            w_sa   = $signed((w_a64 >> (i * w_lw)) << (64 - w_lw)) >>> (64 - w_lw);
            w_sb   = $signed((w_b64 >> (i * w_lw)) << (64 - w_lw)) >>> (64 - w_lw);
            w_t    = f_lane(w_op, w_sa, w_sb);
            w_lane = w_t[63:0];
`ifdef SIMD_SATURATION_EN
            if ((w_op == c_OP_ADD) || (w_op == c_OP_SUB)) begin
               if ($signed(w_t) > $signed({1'b0, w_lim})) begin
                  w_lane = w_lim;
               end else if ($signed(w_t) < $signed({1'b1, ~w_lim})) begin
                  w_lane = ~w_lim;
               end
            end
`endif
            w_pack = w_pack | ((w_lane & w_mask) << (i * w_lw));
         end
      end
      w_res = w_illegal ? '0 : w_pack[XLEN-1:0];
   end

   // Stage k can take new contents when it is empty or its contents move on;
   // the chain ripples back from result_ready_i so a full pipe streams.
   always_comb begin
      logic w_run;
      w_run = bus.result_ready_i;
      w_acc = '0;
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         w_run    = ~r_vld[k] | w_run;
         w_acc[k] = w_run;
      end
   end

   assign bus.issue_ready_o = w_acc[0] & ~bus.flush_i & ~rst_i;

   // Pipeline registers: flush drops every valid bit and the offered op;
   // payload only loads alongside a valid so held outputs never glitch.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_vld <= '0;
         r_exc <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            r_res[k]  <= '0;
            r_tag[k]  <= '0;
            r_code[k] <= '0;
         end
      end else if (bus.flush_i) begin
         r_vld <= '0;
      end else begin
         for (int k = PIPE_DEPTH - 1; k > 0; k--) begin
            if (w_acc[k]) begin
               r_vld[k] <= r_vld[k-1];
               if (r_vld[k-1]) begin
                  r_res[k]  <= r_res[k-1];
                  r_tag[k]  <= r_tag[k-1];
                  r_exc[k]  <= r_exc[k-1];
                  r_code[k] <= r_code[k-1];
               end
            end
         end
         if (w_acc[0]) begin
            r_vld[0] <= bus.issue_valid_i;
            if (bus.issue_valid_i) begin
               r_res[0]  <= w_res;
               r_tag[0]  <= bus.entry_idx_i;
               r_exc[0]  <= w_illegal;
               r_code[0] <= w_illegal ? EXCEPT_LEN'(1) : '0;
            end
         end
      end
   end

   assign bus.result_valid_o  = r_vld[PIPE_DEPTH-1];
   assign bus.result_o        = r_res[PIPE_DEPTH-1];
   assign bus.entry_idx_o     = r_tag[PIPE_DEPTH-1];
   assign bus.except_raised_o = r_exc[PIPE_DEPTH-1];
   assign bus.except_code_o   = r_code[PIPE_DEPTH-1];

endmodule
`default_nettype wire

// File: tb/tb_simd_eu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simd_eu
//  Description : Self-checking bench for simd_eu. An independent lane model
//                fills a scoreboard queue on each accepted issue; results are
//                popped and compared as they are handed off. Directed cases
//                cover the reference vectors, back-pressure, flush and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simd_eu;
   localparam int XLEN       = 64;
   localparam int RS_DEPTH   = 16;
   localparam int PIPE_DEPTH = 2;
   localparam int EU_CTL_LEN = 5;
   localparam int EXCEPT_LEN = 2;
   localparam int IDX_W      = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   simd_eu_if #(.XLEN(XLEN), .IDX_W(IDX_W), .EU_CTL_LEN(EU_CTL_LEN),
                .EXCEPT_LEN(EXCEPT_LEN)) bus ();

   simd_eu #(.XLEN(XLEN), .RS_DEPTH(RS_DEPTH), .PIPE_DEPTH(PIPE_DEPTH),
             .EU_CTL_LEN(EU_CTL_LEN), .EXCEPT_LEN(EXCEPT_LEN)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [63:0] res;
      logic [3:0]  tag;
      logic        exc;
      logic [1:0]  code;
      int          cyc;
      bit          lat;
   } exp_t;

   exp_t        q[$];
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc      = 0;
   bit          lat_chk  = 1'b0;
   bit          saw_full = 1'b0;
   bit          held     = 1'b0;
   logic [63:0] held_res;
   logic [3:0]  held_tag;
   logic        held_exc;
   logic [1:0]  held_code;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed 0x%h, expected 0x%h", tag, got, exp);
      end
   endtask

   function automatic longint lane_get(input logic [63:0] v, input int i, input int w);
      case (w)
         8:       return longint'($signed(v[i*8 +: 8]));
         16:      return longint'($signed(v[i*16 +: 16]));
         32:      return longint'($signed(v[i*32 +: 32]));
         default: return longint'(v);
      endcase
   endfunction

   function automatic logic [63:0] lane_put(input logic [63:0] v, input int i, input int w,
                                            input longint r);
      logic [63:0] o;
      o = v;
      case (w)
         8:       o[i*8 +: 8]   = r[7:0];
         16:      o[i*16 +: 16] = r[15:0];
         32:      o[i*32 +: 32] = r[31:0];
         default: o             = r;
      endcase
      return o;
   endfunction

   function automatic exp_t model(input logic [4:0] ctl, input logic [63:0] a,
                                  input logic [63:0] b, input logic [3:0] tag);
      exp_t        e;
      int          w;
      longint      x, y, r;
      logic [63:0] out;
      longint      hi, lo;
      w     = 8 << ctl[4:3];
      e.tag = tag;
      e.cyc = 0;
      e.lat = 1'b0;
      out   = '0;
      hi    = 0;
      lo    = 0;
      if (ctl[2:0] == 3'b111) begin
         e.res  = '0;
         e.exc  = 1'b1;
         e.code = 2'b01;
         return e;
      end
      for (int i = 0; i < 64 / w; i++) begin
         x = lane_get(a, i, w);
         y = lane_get(b, i, w);
         case (ctl[2:0])
            3'd0:    r = x + y;
            3'd1:    r = x - y;
            3'd2:    r = (x < y) ? x : y;
            3'd3:    r = (x > y) ? x : y;
            3'd4:    r = x & y;
            3'd5:    r = x | y;
            default: r = x ^ y;
         endcase
`ifdef SIMD_SATURATION_EN
         if (ctl[2:1] == 2'b00) begin
            if (w < 64) begin
               hi = (longint'(1) <<< (w - 1)) - 1;
               lo = -hi - 1;
               if (r > hi) r = hi;
               else if (r < lo) r = lo;
            end else begin
               hi = longint'(64'h7FFF_FFFF_FFFF_FFFF);
               lo = longint'(64'h8000_0000_0000_0000);
               if (ctl[0] == 1'b0) begin
                  if (x >= 0 && y >= 0 && r < 0) r = hi;
                  else if (x < 0 && y < 0 && r >= 0) r = lo;
               end else begin
                  if (x >= 0 && y < 0 && r < 0) r = hi;
                  else if (x < 0 && y >= 0 && r >= 0) r = lo;
               end
            end
         end
`endif
         out = lane_put(out, i, w, r);
      end
      e.res  = out;
      e.exc  = 1'b0;
      e.code = 2'b00;
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard: handshakes are judged at the falling edge, i.e. on the
   // values that the next rising edge will act upon.
   always @(negedge clk) begin
      exp_t e;
      if (rst || bus.flush_i) begin
         q.delete();
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", bus.result_valid_o, 1);
            check("hold_result", bus.result_o, held_res);
            check("hold_tag", bus.entry_idx_o, held_tag);
            check("hold_exc", bus.except_raised_o, held_exc);
            check("hold_code", bus.except_code_o, held_code);
         end
         if (bus.result_valid_o && bus.result_ready_i) begin
            if (q.size() == 0) begin
               check("spurious_result", bus.result_valid_o, 0);
            end else begin
               e = q.pop_front();
               check("result", bus.result_o, e.res);
               check("tag", bus.entry_idx_o, e.tag);
               check("except_raised", bus.except_raised_o, e.exc);
               check("except_code", bus.except_code_o, e.code);
               if (e.lat) check("latency", cyc - e.cyc, PIPE_DEPTH);
            end
         end
         held      = bus.result_valid_o && !bus.result_ready_i;
         held_res  = bus.result_o;
         held_tag  = bus.entry_idx_o;
         held_exc  = bus.except_raised_o;
         held_code = bus.except_code_o;
         if (bus.issue_valid_i && bus.issue_ready_o) begin
            e     = model(bus.eu_ctl_i, bus.rs1_i, bus.rs2_i, bus.entry_idx_i);
            e.cyc = cyc;
            e.lat = lat_chk;
            q.push_back(e);
         end
         if (bus.issue_valid_i && !bus.issue_ready_o) saw_full = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] ctl, input logic [63:0] a, input logic [63:0] b,
                        input logic [3:0] tag);
      bit ok;
      ok                = 1'b0;
      bus.issue_valid_i = 1'b1;
      bus.eu_ctl_i      = ctl;
      bus.rs1_i         = a;
      bus.rs2_i         = b;
      bus.entry_idx_i   = tag;
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = bus.issue_ready_o;
         tick();
      end
      bus.issue_valid_i = 1'b0;
      if (!ok) check("issue_timeout", bus.issue_ready_o, 1);
   endtask

   task automatic wait_result(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.result_valid_o && n < 20);
      if (!bus.result_valid_o) check("result_timeout", bus.result_valid_o, 1);
   endtask

   task automatic drain();
      for (int n = 0; n < 200 && q.size() != 0; n++) tick();
      check("drain", q.size(), 0);
   endtask

   function automatic logic [63:0] rnd_data();
      logic [63:0] v;
      v = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) v = 64'h7F80_7FFF_8000_7FFF ^ {32'h0, $urandom_range(0, 1)};
      return v;
   endfunction

   initial begin
      int n;
      bus.flush_i        = 1'b0;
      bus.issue_valid_i  = 1'b0;
      bus.eu_ctl_i       = '0;
      bus.rs1_i          = '0;
      bus.rs2_i          = '0;
      bus.entry_idx_i    = '0;
      bus.result_ready_i = 1'b1;

      // Reset state
      #2;
      check("rst_result_valid", bus.result_valid_o, 0);
      check("rst_result", bus.result_o, 0);
      check("rst_tag", bus.entry_idx_o, 0);
      check("rst_exc", bus.except_raised_o, 0);
      check("rst_code", bus.except_code_o, 0);
      check("rst_issue_ready", bus.issue_ready_o, 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      #1 check("issue_ready_after_rst", bus.issue_ready_o, 1);

      // 8-bit ADD reference vector, latency and tag
      lat_chk = 1'b1;
      issue(5'b00_000, 64'h0102030405060708, 64'h0101010101010101, 4'd5);
      lat_chk = 1'b0;
      wait_result(n);
      check("add8_latency", n, PIPE_DEPTH);
      check("add8_result", bus.result_o, 64'h0203040506070809);
      check("add8_tag", bus.entry_idx_o, 5);
      tick();

      // 8-bit ADD overflow lane behaviour
      issue(5'b00_000, 64'h7F7F7F7F7F7F7F7F, 64'h0101010101010101, 4'd1);
      wait_result(n);
`ifdef SIMD_SATURATION_EN
      check("add8_ovf", bus.result_o, 64'h7F7F7F7F7F7F7F7F);
`else
      check("add8_ovf", bus.result_o, 64'h8080808080808080);
`endif
      check("add8_ovf_exc", bus.except_raised_o, 0);
      tick();

      // 16-bit signed MIN
      issue(5'b01_010, 64'hFFFF000100020003, 64'h0000000000030001, 4'd2);
      wait_result(n);
      check("min16_result", bus.result_o, 64'hFFFF000000020001);
      tick();

      // Illegal op
      issue(5'b10_111, 64'hDEADBEEFCAFEF00D, 64'h1234567812345678, 4'd3);
      wait_result(n);
      check("ill_result", bus.result_o, 0);
      check("ill_exc", bus.except_raised_o, 1);
      check("ill_code", bus.except_code_o, 2'b01);
      check("ill_tag", bus.entry_idx_o, 3);
      tick();

      // Back-to-back stream with ready held high: one op per cycle, fixed latency
      lat_chk = 1'b1;
      for (int i = 0; i < 6; i++)
         issue({2'(i % 4), 3'($urandom_range(0, 6))}, rnd_data(), rnd_data(), 4'(i + 8));
      lat_chk = 1'b0;
      drain();

      // Back-pressure: 4 ops while the consumer stalls
      saw_full           = 1'b0;
      bus.result_ready_i = 1'b0;
      fork
         begin
            issue(5'b00_000, 64'h1111111111111111, 64'h0F0F0F0F0F0F0F0F, 4'd10);
            issue(5'b01_001, 64'h0000000080000000, 64'h0001000100010001, 4'd11);
            issue(5'b10_011, 64'h80000000FFFFFFFF, 64'h7FFFFFFF00000000, 4'd12);
            issue(5'b11_110, 64'hAAAAAAAAAAAAAAAA, 64'hFFFF0000FFFF0000, 4'd13);
         end
         begin
            repeat (6) tick();
            check("bp_issue_ready_dropped", saw_full, 1);
            bus.result_ready_i = 1'b1;
         end
      join
      drain();

      // Random mix with a randomly stalling consumer
      fork
         begin
            for (int i = 0; i < 30; i++)
               issue(5'($urandom_range(0, 31)), rnd_data(), rnd_data(), 4'(i));
         end
         begin
            repeat (60) begin
               bus.result_ready_i = 1'($urandom_range(0, 1));
               tick();
            end
            bus.result_ready_i = 1'b1;
         end
      join
      bus.result_ready_i = 1'b1;
      drain();

      // Flush with two ops in flight and a third on offer
      bus.result_ready_i = 1'b0;
      issue(5'b00_000, 64'h0101010101010101, 64'h0101010101010101, 4'd6);
      issue(5'b00_100, 64'hFFFFFFFFFFFFFFFF, 64'h00FF00FF00FF00FF, 4'd7);
      bus.issue_valid_i = 1'b1;
      bus.eu_ctl_i      = 5'b00_101;
      bus.entry_idx_i   = 4'd8;
      bus.flush_i       = 1'b1;
      @(negedge clk);
      check("flush_issue_ready", bus.issue_ready_o, 0);
      check("flush_pipe_full", bus.result_valid_o, 1);
      tick();
      bus.flush_i        = 1'b0;
      bus.issue_valid_i  = 1'b0;
      bus.result_ready_i = 1'b1;
      @(negedge clk);
      check("flush_result_valid", bus.result_valid_o, 0);
      repeat (5) tick();
      check("flush_no_results", q.size(), 0);

      // Asynchronous reset with ops in flight
      bus.result_ready_i = 1'b0;
      issue(5'b00_000, 64'h1111111111111111, 64'h2222222222222222, 4'd9);
      issue(5'b01_110, 64'h00FF00FF00FF00FF, 64'h0F0F0F0F0F0F0F0F, 4'd14);
      #3 rst = 1'b1;
      #1;
      check("midrst_result_valid", bus.result_valid_o, 0);
      check("midrst_result", bus.result_o, 0);
      check("midrst_tag", bus.entry_idx_o, 0);
      check("midrst_exc", bus.except_raised_o, 0);
      check("midrst_code", bus.except_code_o, 0);
      check("midrst_issue_ready", bus.issue_ready_o, 0);
      tick();
      @(posedge clk);
      #1 rst = 1'b0;
      bus.result_ready_i = 1'b1;
      #1 check("midrst_issue_ready_release", bus.issue_ready_o, 1);
      repeat (5) tick();
      check("midrst_result_after", bus.result_valid_o, 0);
      check("final_queue_empty", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed run still active, expected completion");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/simd_eu.md
SIMD_EU -- requirements
Module: simd_eu

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand/result width (multiple of 64 not required; SHALL be 64 or 32).
REQ-002 SHALL have parameter RS_DEPTH, default 16, reservation-station entries; IDX_W = $clog2(RS_DEPTH).
REQ-003 SHALL have parameter PIPE_DEPTH, default 2, pipeline stages, legal 1..4.
REQ-004 SHALL have parameter EU_CTL_LEN, default 5, control field width; parameter EXCEPT_LEN, default 2, exception code width.
REQ-005 SHALL have ports, clock and reset first; single clock; reset asynchronous, active-high:
- clk_i  in  1  clock
- rst_i  in  1  async active-high reset
- flush_i  in  1  sync pipeline flush
- issue_valid_i  in  1  RS presents operation
- issue_ready_o  out  1  EU accepts operation
- eu_ctl_i  in  EU_CTL_LEN  [2:0] op, [4:3] lane width
- rs1_i, rs2_i  in  XLEN  packed operands
- entry_idx_i  in  IDX_W  RS entry tag
- result_valid_o  out  1  result available
- result_ready_i  in  1  RS consumes result
- result_o  out  XLEN  packed result
- entry_idx_o  out  IDX_W  tag of result
- except_raised_o  out  1  exception flag
- except_code_o  out  EXCEPT_LEN  exception code

Function
REQ-006 Transfer in on issue_valid_i & issue_ready_o at rising clk_i; transfer out on result_valid_o & result_ready_i.
REQ-007 Lane width: 00=8b, 01=16b, 10=32b, 11=64b (11 with XLEN=32 is illegal); lanes = XLEN/width, no carries across lanes.
REQ-008 Ops per lane: 000 ADD, 001 SUB, 010 MIN signed, 011 MAX signed, 100 AND, 101 OR, 110 XOR, 111 illegal.
REQ-009 Illegal op/width: result_o=0, except_raised_o=1, except_code_o=2'b01; otherwise except_raised_o=0, except_code_o=0.
REQ-010 Each stage holds valid bit, result, tag, exception; stage k advances when stage k+1 empty or advancing; last stage advances on result_ready_i.
REQ-011 issue_ready_o = !stage0_valid | stage0_advancing (combinational from result_ready_i chain); no bubbles required.
REQ-012 Latency: result_valid_o asserted exactly PIPE_DEPTH cycles after acceptance with no back-pressure; throughput 1 op/cycle.
REQ-013 Back-pressure: while result_valid_o=1 and result_ready_i=0, result_o, entry_idx_o, exception outputs SHALL stay stable; no op lost or duplicated.
REQ-014 Results SHALL emerge in issue order, tag preserved bit-exact.
REQ-015 flush_i=1 clears all stage valid bits at next edge; op offered in flush cycle discarded; issue_ready_o=0 during flush_i.
REQ-016 flush_i has priority over simultaneous issue and result handshake; result_valid_o=0 cycle after flush.
REQ-017 All outputs except issue_ready_o SHALL be registered.

Reset
REQ-018 rst_i=1 asynchronously clears all valid bits; result_valid_o=0, result_o=0, entry_idx_o=0, except_raised_o=0, except_code_o=0.
REQ-019 issue_ready_o=0 while rst_i=1; =1 first cycle after release.
REQ-020 Reset mid-operation discards all in-flight ops; no result emitted afterwards.

Configuration
REQ-021 Macro SIMD_SATURATION_EN: defined -> ADD/SUB saturate signed per lane (8b: 127/-128, etc.); undefined -> ADD/SUB wrap modulo 2^width.
REQ-022 Saturation SHALL never raise an exception; other ops unaffected by macro.

Verification
REQ-023 8b ADD rs1=0x0102030405060708, rs2=0x0101010101010101, tag 5 -> result 0x0203040506070809, tag 5, after 2 cycles.
REQ-024 8b ADD lanes 0x7F+0x01 -> 0x80 without macro, 0x7F with SIMD_SATURATION_EN.
REQ-025 16b MIN rs1=0xFFFF000100020003, rs2=0x0000000000030001 -> 0xFFFF000000020001.
REQ-026 4 back-to-back ops, result_ready_i low 3 cycles -> outputs stable, issue_ready_o drops when full, all 4 results in order.
REQ-027 op=111, tag 3 -> result 0, except_raised_o=1, except_code_o=01, tag 3.
REQ-028 flush_i with 2 ops in flight plus one offered -> no results emitted; rst_i mid-stream -> all outputs 0 immediately.
